// File: rtl/hub_leaf_endpoint.sv
// Leaf-side hub tree termination: filters hub words down to the local stage controller
// and tags local controller messages with this FPGA's ID on the way back up.

module hub_leaf_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;

  // Callers only push when count < 2 and only pop when count > 0.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + 2'(push) - 2'(pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

module hub_leaf_endpoint #(
  parameter int HUB_FIFO_WIDTH    = 32,
  parameter int MASTER_FIFO_WIDTH = 8,
  parameter int FPGAID_WIDTH      = 4,
  parameter int FPGA_ID           = 2,
  parameter int CNT_WIDTH         = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [HUB_FIFO_WIDTH-1:0]    hub_in_data,
  input  logic                         hub_in_valid,
  output logic                         hub_in_ready,
  output logic [HUB_FIFO_WIDTH-1:0]    hub_out_data,
  output logic                         hub_out_valid,
  input  logic                         hub_out_ready,
  output logic [MASTER_FIFO_WIDTH-1:0] sc_out_data,
  output logic                         sc_out_valid,
  input  logic                         sc_out_ready,
  input  logic [MASTER_FIFO_WIDTH-1:0] sc_in_data,
  input  logic                         sc_in_valid,
  output logic                         sc_in_ready,
  input  logic                         local_has_message_flying,
  input  logic                         local_has_odd_clusters,
  output logic                         upstream_has_message_flying,
  output logic                         upstream_has_odd_clusters,
  output logic [CNT_WIDTH-1:0]         rx_count,
  output logic [CNT_WIDTH-1:0]         drop_count
);

  localparam int HDR_W = HUB_FIFO_WIDTH - MASTER_FIFO_WIDTH;

  logic [FPGAID_WIDTH-1:0]      my_id;
  logic [HDR_W-1:0]             my_hdr;
  logic [HDR_W-1:0]             in_hdr;
  logic                         hdr_match;
  logic                         hub_in_fire;
  logic                         dq_push, dq_pop;
  logic                         uq_push, uq_pop;
  logic [1:0]                   dq_count, uq_count;
  logic [MASTER_FIFO_WIDTH-1:0] dq_head;
  logic [HUB_FIFO_WIDTH-1:0]    uq_head;

  logic [CNT_WIDTH-1:0] rx_count_q, rx_count_d;
  logic [CNT_WIDTH-1:0] drop_count_q, drop_count_d;
  logic                 flying_q, flying_d;
  logic                 odd_q, odd_d;

  assign my_id  = FPGAID_WIDTH'(FPGA_ID);
  assign my_hdr = {{(HDR_W-FPGAID_WIDTH){1'b0}}, my_id};
  assign in_hdr = hub_in_data[HUB_FIFO_WIDTH-1:MASTER_FIFO_WIDTH];

  // Readies look only at occupancy and are forced low while reset is held.
  assign hub_in_ready = reset & (dq_count != 2'd2);
  assign sc_in_ready  = reset & (uq_count != 2'd2);

  assign hdr_match   = (&in_hdr) || (in_hdr == my_hdr);
  assign hub_in_fire = hub_in_valid & hub_in_ready;
  assign dq_push     = hub_in_fire & hdr_match;
  assign sc_out_valid = (dq_count != 2'd0);
  assign dq_pop      = sc_out_valid & sc_out_ready;
  assign sc_out_data = dq_head;

  assign uq_push       = sc_in_valid & sc_in_ready;
  assign hub_out_valid = (uq_count != 2'd0);
  assign uq_pop        = hub_out_valid & hub_out_ready;
  assign hub_out_data  = uq_head;

  hub_leaf_fifo #(.WIDTH(MASTER_FIFO_WIDTH)) u_dq (
    .clk       (clk),
    .reset     (reset),
    .push      (dq_push),
    .push_data (hub_in_data[MASTER_FIFO_WIDTH-1:0]),
    .pop       (dq_pop),
    .head      (dq_head),
    .count     (dq_count)
  );

  hub_leaf_fifo #(.WIDTH(HUB_FIFO_WIDTH)) u_uq (
    .clk       (clk),
    .reset     (reset),
    .push      (uq_push),
    .push_data ({my_hdr, sc_in_data}),
    .pop       (uq_pop),
    .head      (uq_head),
    .count     (uq_count)
  );

  // Statistics counters stick at all ones rather than wrapping.
  always_comb begin
    rx_count_d   = rx_count_q;
    drop_count_d = drop_count_q;
    if (dq_pop && (rx_count_q != '1)) begin
      rx_count_d = rx_count_q + CNT_WIDTH'(1);
    end
    if (hub_in_fire && !hdr_match && (drop_count_q != '1)) begin
      drop_count_d = drop_count_q + CNT_WIDTH'(1);
    end
    flying_d = local_has_message_flying | (dq_count != 2'd0) | (uq_count != 2'd0)
             | hub_in_valid | sc_in_valid;
    odd_d    = local_has_odd_clusters;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_count_q   <= '0;
      drop_count_q <= '0;
      flying_q     <= 1'b0;
      odd_q        <= 1'b0;
    end else begin
      rx_count_q   <= rx_count_d;
      drop_count_q <= drop_count_d;
      flying_q     <= flying_d;
      odd_q        <= odd_d;
    end
  end

  assign rx_count                    = rx_count_q;
  assign drop_count                  = drop_count_q;
  assign upstream_has_message_flying = flying_q;
  assign upstream_has_odd_clusters   = odd_q;

endmodule

// File: doc/hub_leaf_endpoint.md
Name: hub_leaf_endpoint

Overview:
Leaf-side termination of the hub message tree. It is the counterpart of the root stage-controller master that injects broadcast words into the hub network.
- Receives hub words from the upstream hub and filters them by destination (broadcast or own FPGA ID).
- Strips the header and delivers the payload to the local slave stage controller.
- In the reverse direction, prefixes local controller messages with a source header before sending them upstream.
- Reports aggregated has_message_flying / has_odd_clusters status upstream.

Parameters:
- HUB_FIFO_WIDTH, 32, full hub word width.
- MASTER_FIFO_WIDTH, 8, payload width (low bits of a hub word).
- FPGAID_WIDTH, 4, width of the FPGA ID field.
- FPGA_ID, 2, this leaf's ID.
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- hub_in_data  in  HUB_FIFO_WIDTH  word from upstream hub
- hub_in_valid  in  1  hub_in_data valid
- hub_in_ready  out  1  endpoint accepts hub_in word
- hub_out_data  out  HUB_FIFO_WIDTH  word to upstream hub
- hub_out_valid  out  1  hub_out_data valid
- hub_out_ready  in  1  hub accepts hub_out word
- sc_out_data  out  MASTER_FIFO_WIDTH  payload to local stage controller
- sc_out_valid  out  1  sc_out_data valid
- sc_out_ready  in  1  controller accepts payload
- sc_in_data  in  MASTER_FIFO_WIDTH  payload from local stage controller
- sc_in_valid  in  1  sc_in_data valid
- sc_in_ready  out  1  endpoint accepts sc_in payload
- local_has_message_flying  in  1  local PU array has messages in flight
- local_has_odd_clusters  in  1  local array has odd clusters
- upstream_has_message_flying  out  1  registered aggregate flag to hub
- upstream_has_odd_clusters  out  1  registered flag to hub
- rx_count  out  CNT_WIDTH  payloads delivered to sc_out
- drop_count  out  CNT_WIDTH  hub words discarded by the filter

Behaviour:
- Reset (reset=0, async): both buffers empty, all valids 0, both flags 0, both counters 0, all data outputs 0. Ready outputs are 0 while in reset.
- Header definition: HDR = hub word bits [HUB_FIFO_WIDTH-1:MASTER_FIFO_WIDTH]; payload = bits [MASTER_FIFO_WIDTH-1:0].
- Downstream path (hub to controller):
  - 2-entry FIFO DQ. hub_in_ready = (DQ count < 2); this depends only on count, so a word is not accepted when DQ is full even if a pop occurs in the same cycle.
  - On handshake, HDR is classified as broadcast if all ones, or as addressed-to-me if it equals FPGA_ID zero-extended.
  - Broadcast or addressed-to-me: the payload is pushed to DQ.
  - Otherwise: the word is consumed (ready honoured), not stored, and drop_count increments.
  - sc_out_valid = DQ non-empty; sc_out_data = DQ head.
  - Pop on sc_out_valid & sc_out_ready; rx_count increments on each pop.
  - Latency: a word accepted in cycle N appears on sc_out in cycle N+1 when DQ was empty.
- Upstream path (controller to hub):
  - 2-entry FIFO UQ. sc_in_ready = (UQ count < 2).
  - Stored word = {zero-extended FPGA_ID in HDR, sc_in_data}.
  - hub_out_valid = UQ non-empty; pop on hub_out_valid & hub_out_ready. Same 1-cycle latency.
- Both FIFOs:
  - Strict FIFO order.
  - Simultaneous push and pop with count 1 keeps count at 1.
  - Head data is stable while valid & !ready.
- Counters saturate at all ones (no wrap).
- Flags, registered each cycle:
  - upstream_has_message_flying = local_has_message_flying | DQ non-empty | UQ non-empty | hub_in_valid | sc_in_valid.
  - upstream_has_odd_clusters = local_has_odd_clusters.
- Reset asserted mid-transfer: in-flight words are discarded; after release, no stale valid appears.

Test Plan:
- Broadcast: hub_in 0xFFFFFF5A with sc_out_ready=1 → sc_out_data=0x5A, sc_out_valid high for exactly 1 cycle, next cycle; rx_count=1.
- Addressed: hub_in 0x0000025A → delivered as 0x5A. Then 0x0000035A → hub_in_ready stays 1, nothing on sc_out, drop_count=1.
- Upstream: sc_in 0x3C → hub_out_data=0x0000023C next cycle. With hub_out_ready=0 held for 5 cycles, data holds stable and sc_in_ready drops after 2 words; release → words emerge in order.
- Backpressure: sc_out_ready=0, three broadcasts 0x01, 0x02, 0x03 → hub_in_ready=0 after the second; release → 0x01, 0x02, 0x03 in order, rx_count=3.
- Flags: locals 0, queues empty → both flags 0. Pulse local_has_odd_clusters one cycle → upstream flag high exactly one cycle later. A word held in DQ keeps upstream_has_message_flying=1.
- Reset mid-op with 2 words queued → all outputs reset immediately (async). After release, sc_out_valid=0 and counters=0. Drop_count preset to all ones stays saturated on a further drop.
